// File: rtl/aes_pack_pkg.sv
// aes_pack_pkg: shared FSM encoding and constants for the AES output packer.
// Revision: 1.0
`default_nettype none

package aes_pack_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  localparam logic [15:0] BLK_TAG        = 16'hB10C;
  localparam int          BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/aes_pack_buf.sv
// aes_pack_buf: synchronous BUF_DEPTH x DATA_WIDTH FIFO, first-word-fall-through head.
// Revision: 1.0
`default_nettype none

module aes_pack_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic                         pop_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(BUF_DEPTH):0]   count_o
);

  localparam int AW = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(BUF_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full buffer is still accepted.
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_out_packer.sv
// aes_out_packer: packs byte-serial AES ciphertext into 32-bit words and drains them to a FIFO.
// Revision: 1.0 -- define AES_PACK_TAG_EN to prefix every block with a {16'hB10C, blk_cnt} header.
`default_nettype none

module aes_out_packer
  import aes_pack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 8,
  parameter int BLK_BYTES  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            d_out,
  input  logic                  d_vld,
  input  logic                  abort,
  input  logic                  data_full,
  output logic                  data_wr,
  output logic [DATA_WIDTH-1:0] data_dout,
  output logic                  block_done,
  output logic                  overflow,
  output logic                  busy
);

  localparam int CW = $clog2(BLK_BYTES);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [23:0]           word_q, word_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
  logic                  data_wr_q, data_wr_d;
  logic [DATA_WIDTH-1:0] data_dout_q, data_dout_d;
  logic                  block_done_q, block_done_d;
  logic                  overflow_q, overflow_d;
`ifdef AES_PACK_TAG_EN
  logic [15:0]           blk_cnt_q, blk_cnt_d;
`endif

  logic                  buf_full, buf_empty, pop, drop;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic [$clog2(BUF_DEPTH):0] buf_count;

  aes_pack_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push_q),
    .wdata_i (push_data_q),
    .pop_i   (pop),
    .rdata_o (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign pop  = ~buf_empty & ~data_full;
  assign drop = push_q & buf_full & ~pop;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    data_wr_d    = pop;
    data_dout_d  = pop ? buf_rdata : data_dout_q;
    block_done_d = 1'b0;
    overflow_d   = overflow_q | drop;
`ifdef AES_PACK_TAG_EN
    blk_cnt_d    = blk_cnt_q;
`endif
    // The core cannot stall, so abort simply outranks a coincident byte.
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (d_vld) begin
      state_d = ST_COLLECT;
      case (cnt_q[1:0])
        2'd0: word_d[7:0]   = d_out;
        2'd1: word_d[15:8]  = d_out;
        2'd2: word_d[23:16] = d_out;
        default: begin
          push_d      = 1'b1;
          push_data_d = {d_out, word_q};
        end
      endcase
`ifdef AES_PACK_TAG_EN
      if (cnt_q == '0) begin
        push_d      = 1'b1;
        push_data_d = {BLK_TAG, blk_cnt_q};
      end
`endif
      if (cnt_q == CW'(BLK_BYTES - 1)) begin
        cnt_d        = '0;
        state_d      = ST_IDLE;
        block_done_d = 1'b1;
`ifdef AES_PACK_TAG_EN
        blk_cnt_d    = blk_cnt_q + 16'd1;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      data_wr_q    <= 1'b0;
      data_dout_q  <= '0;
      block_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      data_wr_q    <= data_wr_d;
      data_dout_q  <= data_dout_d;
      block_done_q <= block_done_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef AES_PACK_TAG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) blk_cnt_q <= '0;
    else          blk_cnt_q <= blk_cnt_d;
  end
`endif

  assign data_wr    = data_wr_q;
  assign data_dout  = data_dout_q;
  assign block_done = block_done_q;
  assign overflow   = overflow_q;
  // A completed word still in flight to the buffer counts as pending work.
  assign busy       = (state_q == ST_COLLECT) | (buf_count != '0) | push_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_out_packer.sv
// tb_aes_out_packer: directed self-checking bench for aes_out_packer.
// Revision: 1.0
`default_nettype none

module tb_aes_out_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  d_out = 8'h00;
  logic        d_vld = 1'b0;
  logic        abort = 1'b0;
  logic        data_full = 1'b0;
  logic        data_wr;
  logic [31:0] data_dout;
  logic        block_done;
  logic        overflow;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_bd  = 0;
  int          cyc   = 0;
  logic [31:0] got[$];
  int          gcyc[$];

  aes_out_packer #(
    .DATA_WIDTH (32),
    .BUF_DEPTH  (8),
    .BLK_BYTES  (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .d_out      (d_out),
    .d_vld      (d_vld),
    .abort      (abort),
    .data_full  (data_full),
    .data_wr    (data_wr),
    .data_dout  (data_dout),
    .block_done (block_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (data_wr) begin
      got.push_back(data_dout);
      gcyc.push_back(cyc);
    end
    if (block_done) n_bd = n_bd + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    d_vld = 1'b0; abort = 1'b0;
    tick(1);
    reset_n = 1'b1;
    got.delete();
    gcyc.delete();
    n_bd = 0;
  endtask

  // Drives n consecutive bytes start, start+1, ...; returns after the last is captured.
  task automatic send_bytes(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      d_vld = 1'b1;
      d_out = start + 8'(i);
      tick(1);
    end
    d_vld = 1'b0;
  endtask

  function automatic logic [31:0] wexp(input logic [7:0] b0);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    tick(2);
    check_eq("rst_data_wr",    {31'd0, data_wr},    32'd0);
    check_eq("rst_data_dout",  data_dout,           32'd0);
    check_eq("rst_block_done", {31'd0, block_done}, 32'd0);
    check_eq("rst_overflow",   {31'd0, overflow},   32'd0);
    check_eq("rst_busy",       {31'd0, busy},       32'd0);
    reset_n = 1'b1;
    tick(2);

`ifndef AES_PACK_TAG_EN
    // One block, no back-pressure.
    do_reset();
    send_bytes(8'h00, 16);
    tick(8);
    check_eq("t1_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("t1_word", got_at(i), wexp(8'(4 * i)));
    check_eq("t1_block_done", 32'(n_bd), 32'd1);
    check_eq("t1_overflow", {31'd0, overflow}, 32'd0);
    check_eq("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Two blocks held back, then released as a back-to-back burst.
    do_reset();
    data_full = 1'b1;
    send_bytes(8'h00, 32);
    tick(4);
    check_eq("t2_held", 32'(got.size()), 32'd0);
    check_eq("t2_busy", {31'd0, busy}, 32'd1);
    data_full = 1'b0;
    tick(14);
    check_eq("t2_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) check_eq("t2_word", got_at(i), wexp(8'(4 * i)));
    check_eq("t2_burst", (gcyc.size() == 8) ? 32'(gcyc[7] - gcyc[0]) : 32'hFFFF_FFFF, 32'd7);
    check_eq("t2_overflow", {31'd0, overflow}, 32'd0);

    // Three blocks into an 8-deep buffer: the third block is dropped.
    do_reset();
    data_full = 1'b1;
    send_bytes(8'h00, 48);
    tick(4);
    check_eq("t3_overflow", {31'd0, overflow}, 32'd1);
    check_eq("t3_block_done", 32'(n_bd), 32'd3);
    data_full = 1'b0;
    tick(14);
    check_eq("t3_count", 32'(got.size()), 32'd8);
    check_eq("t3_first", got_at(0), 32'h03020100);
    check_eq("t3_last",  got_at(7), 32'h1F1E1D1C);
    check_eq("t3_sticky", {31'd0, overflow}, 32'd1);

    // Abort on the 6th byte; the first word completed earlier and survives.
    do_reset();
    send_bytes(8'h50, 5);
    d_vld = 1'b1; d_out = 8'h55; abort = 1'b1;
    tick(1);
    d_vld = 1'b0; abort = 1'b0;
    tick(2);
    send_bytes(8'hA0, 16);
    tick(8);
    check_eq("t4_count", 32'(got.size()), 32'd5);
    check_eq("t4_pre",  got_at(0), 32'h53525150);
    check_eq("t4_w0",   got_at(1), 32'hA3A2A1A0);
    check_eq("t4_w1",   got_at(2), 32'hA7A6A5A4);
    check_eq("t4_w2",   got_at(3), 32'hABAAA9A8);
    check_eq("t4_w3",   got_at(4), 32'hAFAEADAC);
    check_eq("t4_block_done", 32'(n_bd), 32'd1);

    // Reset mid-block with three words buffered.
    do_reset();
    data_full = 1'b1;
    send_bytes(8'h10, 14);
    tick(2);
    check_eq("t5_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #2;
    check_eq("t5_busy",      {31'd0, busy},       32'd0);
    check_eq("t5_data_wr",   {31'd0, data_wr},    32'd0);
    check_eq("t5_data_dout", data_dout,           32'd0);
    tick(1);
    reset_n = 1'b1;
    data_full = 1'b0;
    tick(10);
    check_eq("t5_no_drain", 32'(got.size()), 32'd0);
    check_eq("t5_overflow", {31'd0, overflow}, 32'd0);
`else
    // Tagged build: each block carries a header with the running block count.
    do_reset();
    send_bytes(8'h00, 32);
    tick(10);
    check_eq("t6_count", 32'(got.size()), 32'd10);
    check_eq("t6_hdr0", got_at(0), 32'hB10C0000);
    for (int i = 0; i < 4; i++) check_eq("t6_blk0", got_at(1 + i), wexp(8'(4 * i)));
    check_eq("t6_hdr1", got_at(5), 32'hB10C0001);
    for (int i = 0; i < 4; i++) check_eq("t6_blk1", got_at(6 + i), wexp(8'(16 + 4 * i)));
    check_eq("t6_block_done", 32'(n_bd), 32'd2);
    check_eq("t6_overflow", {31'd0, overflow}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
